// File: rtl/axis_fifo_pkg.sv
// Shared helpers and reset-state constants for the single-clock AXI4-Stream FIFO.
package axis_fifo_pkg;

  function automatic int fifo_depth(input int addr_wdth);
    return 1 << addr_wdth;
  endfunction

  localparam logic RST_S_TREADY    = 1'b0;
  localparam logic RST_M_TVALID    = 1'b0;
  localparam logic RST_ALMOST_FULL = 1'b0;
  localparam logic RST_ALMOST_EMPT = 1'b1;

endpackage

// File: rtl/axis_fifo_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the storage array is not.
module axis_fifo_sdpram #(
  parameter int ADDR_WDTH = 4,
  parameter int WDTH      = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_WDTH-1:0] waddr,
  input  logic [WDTH-1:0]      wdata,
  input  logic                 re,
  input  logic [ADDR_WDTH-1:0] raddr,
  output logic [WDTH-1:0]      rdata
);
  localparam int DEPTH = 1 << ADDR_WDTH;

  logic [WDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axis_sync_fifo_ctrl.sv
// Single-clock AXI4-Stream FIFO with tlast, registered fill level and almost flags.
// Define AXIS_FIFO_PKT_MODE_EN for store-and-forward (packet) mode.
module axis_sync_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter int ADDR_WDTH     = 4,
  parameter int DATA_WDTH     = 8,
  parameter int AFULL_THRESH  = (1 << ADDR_WDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 axis_clk,
  input  logic                 axis_aresetn,
  input  logic [DATA_WDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [DATA_WDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [ADDR_WDTH:0]   fill_level,
  output logic                 almost_full,
  output logic                 almost_empty
);
  localparam int DEPTH = fifo_depth(ADDR_WDTH);
  typedef logic [ADDR_WDTH:0] ptr_t;
  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THRESH);

  ptr_t wr_ptr, rd_ptr, fill_next;
  logic wr, rd, load, ram_has, pkt_ok;
  logic [DATA_WDTH:0] rdata;

  assign wr      = s_axis_tvalid & s_axis_tready;
  assign rd      = m_axis_tvalid & m_axis_tready;
  assign ram_has = (wr_ptr != rd_ptr);
  // The RAM read register is the output stage, so a load is a RAM read.
  assign load    = ram_has & pkt_ok & (~m_axis_tvalid | m_axis_tready);

`ifdef AXIS_FIFO_PKT_MODE_EN
  ptr_t pkt_cnt;
  logic full;

  assign full   = (fill_level == DEPTH_P);
  // Full escape lets a packet longer than the FIFO drain in cut-through.
  assign pkt_ok = (pkt_cnt != '0) | full;

  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn) pkt_cnt <= '0;
    else if ((wr & s_axis_tlast) & ~(rd & m_axis_tlast)) pkt_cnt <= pkt_cnt + ptr_t'(1);
    else if (~(wr & s_axis_tlast) & (rd & m_axis_tlast)) pkt_cnt <= pkt_cnt - ptr_t'(1);
  end
`else
  assign pkt_ok = 1'b1;
`endif

  always_comb begin
    fill_next = fill_level;
    if (wr & ~rd)      fill_next = fill_level + ptr_t'(1);
    else if (rd & ~wr) fill_next = fill_level - ptr_t'(1);
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      s_axis_tready <= RST_S_TREADY;
      m_axis_tvalid <= RST_M_TVALID;
      almost_full   <= RST_ALMOST_FULL;
      almost_empty  <= RST_ALMOST_EMPT;
    end else begin
      if (wr)   wr_ptr <= wr_ptr + ptr_t'(1);
      if (load) rd_ptr <= rd_ptr + ptr_t'(1);
      fill_level    <= fill_next;
      s_axis_tready <= (fill_next < DEPTH_P);
      almost_full   <= (fill_next >= AFULL_P);
      almost_empty  <= (fill_next <= AEMPTY_P);
      if (load)    m_axis_tvalid <= 1'b1;
      else if (rd) m_axis_tvalid <= 1'b0;
    end
  end

  axis_fifo_sdpram #(
    .ADDR_WDTH (ADDR_WDTH),
    .WDTH      (DATA_WDTH + 1)
  ) u_ram (
    .clk   (axis_clk),
    .rst_n (axis_aresetn),
    .we    (wr),
    .waddr (wr_ptr[ADDR_WDTH-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .re    (load),
    .raddr (rd_ptr[ADDR_WDTH-1:0]),
    .rdata (rdata)
  );

  assign {m_axis_tlast, m_axis_tdata} = rdata;
endmodule

// File: tb/tb_axis_sync_fifo_ctrl.sv
// Directed bench for axis_sync_fifo_ctrl (DEPTH=16, DATA_WDTH=8, AF=14, AE=2).
module tb_axis_sync_fifo_ctrl;
`ifdef AXIS_FIFO_PKT_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic       axis_clk = 1'b0;
  logic       axis_aresetn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [4:0] fill_level;
  logic       almost_full, almost_empty;

  always #5 axis_clk = ~axis_clk;

  axis_sync_fifo_ctrl #(
    .ADDR_WDTH(4), .DATA_WDTH(8), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .axis_clk(axis_clk), .axis_aresetn(axis_aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .fill_level(fill_level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  typedef struct {
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic       tr;
    logic       e_srdy;
    logic       e_tv;
    logic       e_tl;
    logic [7:0] e_td;
    logic [4:0] e_fill;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t       vecs [10];
  logic [8:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic lastbit(input logic [7:0] d);
    return PKT ? 1'b1 : d[0];
  endfunction

  // Scoreboard the handshakes that happen at the coming edge, then advance.
  task automatic cycle();
    logic [8:0] e;
    if (s_axis_tvalid && s_axis_tready) exp_q.push_back({s_axis_tlast, s_axis_tdata});
    if (m_axis_tvalid && m_axis_tready) begin
      rd_cnt++;
      if (exp_q.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("rd_word", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
      end
    end
    @(posedge axis_clk); #1;
  endtask

  task automatic drain(input int budget);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < budget && (m_axis_tvalid || exp_q.size() > 0); k++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  function automatic vec_t mk(input logic tv, input logic [7:0] td, input logic tl, input logic tr,
                              input logic srdy, input logic etv, input logic etl, input logic [7:0] etd,
                              input logic [4:0] fill, input logic af, input logic ae);
    vec_t v;
    v.tv = tv; v.td = td; v.tl = tl; v.tr = tr;
    v.e_srdy = srdy; v.e_tv = etv; v.e_tl = etl; v.e_td = etd;
    v.e_fill = fill; v.e_af = af; v.e_ae = ae;
    return v;
  endfunction

  initial begin
    int rd0, sent;
    bit seen;
    logic tl4;

    tl4 = PKT;
    vecs[0] = mk(0, 8'h00, 0,   1, 1, 0, 0,   8'h00, 0, 0, 1);
    vecs[1] = mk(1, 8'hBA, 1,   1, 1, 0, 0,   8'h00, 1, 0, 1);
    vecs[2] = mk(0, 8'h00, 0,   1, 1, 1, 1,   8'hBA, 1, 0, 1);
    vecs[3] = mk(0, 8'h00, 0,   1, 1, 0, 1,   8'hBA, 0, 0, 1);
    vecs[4] = mk(1, 8'h3C, tl4, 0, 1, 0, 1,   8'hBA, 1, 0, 1);
    vecs[5] = mk(0, 8'h00, 0,   0, 1, 1, tl4, 8'h3C, 1, 0, 1);
    vecs[6] = mk(0, 8'h00, 0,   0, 1, 1, tl4, 8'h3C, 1, 0, 1);
    vecs[7] = mk(1, 8'h5A, 1,   1, 1, 0, tl4, 8'h3C, 1, 0, 1);
    vecs[8] = mk(0, 8'h00, 0,   1, 1, 1, 1,   8'h5A, 1, 0, 1);
    vecs[9] = mk(0, 8'h00, 0,   1, 1, 0, 1,   8'h5A, 0, 0, 1);

    axis_aresetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    chk("rst_state", 32'({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, fill_level, almost_full, almost_empty}),
        32'({1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1}));

    // Single-word path, stall and simultaneous write/read from the table.
    axis_aresetn = 1'b1;
    foreach (vecs[i]) begin
      s_axis_tvalid = vecs[i].tv; s_axis_tdata = vecs[i].td;
      s_axis_tlast = vecs[i].tl; m_axis_tready = vecs[i].tr;
      @(posedge axis_clk); #1;
      chk($sformatf("vec%0d", i),
          32'({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, fill_level, almost_full, almost_empty}),
          32'({vecs[i].e_srdy, vecs[i].e_tv, vecs[i].e_tl, vecs[i].e_td, vecs[i].e_fill, vecs[i].e_af, vecs[i].e_ae}));
    end
    s_axis_tvalid = 1'b0;

    // Fill to full with the sink stalled.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(i); s_axis_tlast = 1'b1;
      cycle();
      chk($sformatf("fill_w%0d", i), 32'(fill_level), 32'(i + 1));
      chk($sformatf("afull_w%0d", i), 32'(almost_full), 32'(i + 1 >= 14));
      chk($sformatf("srdy_w%0d", i), 32'(s_axis_tready), 32'(i + 1 < 16));
    end
    s_axis_tdata = 8'hEE;
    cycle();
    chk("full_no_write", 32'(fill_level), 32'(16));
    chk("full_tvalid", 32'(m_axis_tvalid), 32'(1));

    // Drain in order.
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_tv%0d", k), 32'(m_axis_tvalid), 32'(1));
      cycle();
      chk($sformatf("drain_fill%0d", k), 32'(fill_level), 32'(15 - k));
      chk($sformatf("drain_ae%0d", k), 32'(almost_empty), 32'(15 - k <= 2));
      chk($sformatf("drain_af%0d", k), 32'(almost_full), 32'(15 - k >= 14));
    end
    chk("drain_tv_end", 32'(m_axis_tvalid), 32'(0));

    // Continuous streaming across several pointer wraps.
    rd0 = rd_cnt;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h20 + c); s_axis_tlast = lastbit(8'(8'h20 + c));
      cycle();
      if (c >= 1) begin
        chk($sformatf("stream_fill%0d", c), 32'(fill_level), 32'(2));
        chk($sformatf("stream_tv%0d", c), 32'(m_axis_tvalid), 32'(1));
      end
    end
    drain(10);
    chk("stream_count", 32'(rd_cnt - rd0), 32'(100));

    // Reset mid-stream at fill_level 7.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h40 + i); s_axis_tlast = lastbit(8'(8'h40 + i));
      cycle();
    end
    chk("pre_rst_fill", 32'(fill_level), 32'(7));
    axis_aresetn = 1'b0; s_axis_tdata = 8'h77;
    @(posedge axis_clk); #1;
    exp_q.delete();
    chk("mid_rst_state", 32'({s_axis_tready, m_axis_tvalid, m_axis_tdata, fill_level, almost_full, almost_empty}),
        32'({1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1}));
    axis_aresetn = 1'b1; s_axis_tvalid = 1'b0;
    @(posedge axis_clk); #1;
    chk("post_rst_srdy", 32'(s_axis_tready), 32'(1));
    rd0 = rd_cnt;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'hDA + i); s_axis_tlast = lastbit(8'(8'hDA + i));
      cycle();
    end
    drain(10);
    chk("post_rst_count", 32'(rd_cnt - rd0), 32'(3));

`ifdef AXIS_FIFO_PKT_MODE_EN
    // Store-and-forward: nothing leaves until the packet's tlast is in.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h60 + i); s_axis_tlast = (i == 4);
      cycle();
      chk($sformatf("pkt_hold%0d", i), 32'(m_axis_tvalid), 32'(0));
    end
    s_axis_tvalid = 1'b0;
    cycle();
    chk("pkt_release", 32'(m_axis_tvalid), 32'(1));
    drain(20);

    // A 20-word packet only starts moving once the FIFO is full.
    rd0 = rd_cnt; sent = 0; seen = 1'b0;
    for (int c = 0; c < 400 && (rd_cnt - rd0) < 20; c++) begin
      if (!seen && m_axis_tvalid) begin
        seen = 1'b1;
        chk("pkt_long_full", 32'(fill_level), 32'(16));
      end
      s_axis_tvalid = (sent < 20); s_axis_tdata = 8'(8'h80 + sent); s_axis_tlast = (sent == 19);
      if (s_axis_tvalid && s_axis_tready) sent++;
      cycle();
    end
    s_axis_tvalid = 1'b0;
    chk("pkt_long_count", 32'(rd_cnt - rd0), 32'(20));
    chk("pkt_long_left", 32'(exp_q.size()), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
